// File: rtl/vga_timing_gen_if.sv
// Pixel bus between the VGA timing generator and its upstream pixel source / downstream DAC.
interface vga_timing_gen_if #(
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 10,
  parameter int unsigned RGB_W = 3
) ();
  logic [RGB_W-1:0] PixIn;
  logic             PixEn;
  logic [XW-1:0]    PixX;
  logic [YW-1:0]    PixY;
  logic             LineStart;
  logic             FrameStart;
  logic             hSync;
  logic             nhSync;
  logic             vSync;
  logic             nvSync;
  logic             hBright;
  logic             vBright;
  logic [RGB_W-1:0] VidOut;

  modport master (
    input  PixIn,
    output PixEn, PixX, PixY, LineStart, FrameStart,
    output hSync, nhSync, vSync, nvSync, hBright, vBright, VidOut
  );

  modport slave (
    output PixIn,
    input  PixEn, PixX, PixY, LineStart, FrameStart,
    input  hSync, nhSync, vSync, nvSync, hBright, vBright, VidOut
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered sync/blank/video output stage.
// Define VGA_TEST_PATTERN_EN to replace PixIn with an internal 8-bar colour pattern.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10,
  parameter int unsigned RGB_W    = 3
) (
  input  logic             CLK,
  input  logic             CLR,
  vga_timing_gen_if.master vif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CH_W    = RGB_W / 3;

  logic [DW-1:0]    div_q, div_d;
  logic [XW-1:0]    h_cnt_q, h_cnt_d;
  logic [YW-1:0]    v_cnt_q, v_cnt_d;
  logic             h_sync_q, h_sync_d;
  logic             v_sync_q, v_sync_d;
  logic             h_bright_q, h_bright_d;
  logic             v_bright_q, v_bright_d;
  logic [RGB_W-1:0] vid_q, vid_d;

  logic             pix_en;
  logic             h_wrap, v_wrap;
  logic             hs, hb, vs, vb;
  logic [RGB_W-1:0] pix_src;

  // Region decode from the raw counters; compared at 32 bits so HS_END/VS_END cannot overflow.
  always_comb begin
    pix_en = (div_q == DW'(CLK_DIV - 1));
    h_wrap = (32'(h_cnt_q) == H_TOTAL - 1);
    v_wrap = (32'(v_cnt_q) == V_TOTAL - 1);
    hs     = (32'(h_cnt_q) >= HS_BEG) && (32'(h_cnt_q) < HS_END);
    hb     = (32'(h_cnt_q) <  H_ACTIVE);
    vs     = (32'(v_cnt_q) >= VS_BEG) && (32'(v_cnt_q) < VS_END);
    vb     = (32'(v_cnt_q) <  V_ACTIVE);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_PX = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int unsigned PW     = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

  logic [2:0]    bar_q, bar_d;
  logic [PW-1:0] bar_px_q, bar_px_d;
  logic          unused_pix_in;

  assign unused_pix_in = ^vif.PixIn;

  // Bar index tracks the current hCnt; it is zero whenever hCnt is zero (every LineStart).
  always_comb begin
    bar_d    = bar_q;
    bar_px_d = bar_px_q;
    if (pix_en) begin
      if (h_wrap) begin
        bar_d    = '0;
        bar_px_d = '0;
      end else if (hb) begin
        if (32'(bar_px_q) == BAR_PX - 1) begin
          bar_px_d = '0;
          bar_d    = bar_q + 3'(1);
        end else begin
          bar_px_d = bar_px_q + PW'(1);
        end
      end
    end
    pix_src = {{CH_W{bar_q[2]}}, {CH_W{bar_q[1]}}, {CH_W{bar_q[0]}}};
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      bar_q    <= '0;
      bar_px_q <= '0;
    end else begin
      bar_q    <= bar_d;
      bar_px_q <= bar_px_d;
    end
  end
`else
  assign pix_src = vif.PixIn;
`endif

  // Divider, raster counters and the one-pixel-late output stage all step together on pix_en.
  always_comb begin
    div_d      = pix_en ? '0 : div_q + DW'(1);
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    h_sync_d   = h_sync_q;
    v_sync_d   = v_sync_q;
    h_bright_d = h_bright_q;
    v_bright_d = v_bright_q;
    vid_d      = vid_q;
    if (pix_en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + XW'(1);
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + YW'(1);
      end
      h_sync_d   = hs;
      v_sync_d   = vs;
      h_bright_d = hb;
      v_bright_d = vb;
      vid_d      = (hb && vb) ? pix_src : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      div_q      <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      h_sync_q   <= 1'b0;
      v_sync_q   <= 1'b0;
      h_bright_q <= 1'b0;
      v_bright_q <= 1'b0;
      vid_q      <= '0;
    end else begin
      div_q      <= div_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      h_sync_q   <= h_sync_d;
      v_sync_q   <= v_sync_d;
      h_bright_q <= h_bright_d;
      v_bright_q <= v_bright_d;
      vid_q      <= vid_d;
    end
  end

  assign vif.PixEn      = pix_en;
  assign vif.PixX       = h_cnt_q;
  assign vif.PixY       = v_cnt_q;
  assign vif.LineStart  = pix_en && (h_cnt_q == '0);
  assign vif.FrameStart = pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign vif.hSync      = h_sync_q;
  assign vif.nhSync     = ~h_sync_q;
  assign vif.vSync      = v_sync_q;
  assign vif.nvSync     = ~v_sync_q;
  assign vif.hBright    = h_bright_q;
  assign vif.vBright    = v_bright_q;
  assign vif.VidOut     = vid_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and pixel output stage, replacing the fixed 640x480 timing inside `VGA_Top`. It divides the system clock to a pixel-rate enable, runs horizontal and vertical counters for any resolution and porch set, and publishes pixel coordinates to an upstream pixel source. It also produces sync/blanking, registered and delayed to line up with that source, and drives blank-gated video.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal front porch, sync and back porch widths, in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical front porch, sync and back porch widths, in lines
- `CLK_DIV`, 2, CLK cycles per pixel (≥1)
- `XW`, 10; `YW`, 10: coordinate widths; must hold H_TOTAL-1 and V_TOTAL-1
- `RGB_W`, 3, video width (multiple of 3)
- `CLK` in 1: system clock, rising edge
- `CLR` in 1: reset; one clock; synchronous, active-high
- `PixIn` in RGB_W: pixel for the coordinate presented on the previous PixEn
- `PixEn` out 1: pixel-rate enable, one CLK wide
- `PixX` out XW, `PixY` out YW: coordinate being requested (raw counters)
- `LineStart` out 1, `FrameStart` out 1: one-CLK pulses
- `hSync`/`nhSync` out 1: horizontal sync, active-high, plus its complement
- `vSync`/`nvSync` out 1: vertical sync, active-high, plus its complement
- `hBright`, `vBright` out 1: active-region flags, aligned to VidOut
- `VidOut` out RGB_W: video, zero when not bright

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the vertical parameters.
- Divider `div` counts 0..CLK_DIV-1 and wraps. PixEn = (div==CLK_DIV-1). When CLK_DIV=1, PixEn is constantly 1.
- Counters `hCnt`/`vCnt` drive PixX/PixY directly and advance only on PixEn:
  - hCnt==H_TOTAL-1: hCnt→0.
  - Otherwise hCnt increments.
  - vCnt increments when hCnt wraps; at V_TOTAL-1 it wraps to 0.
- Region order per line is active [0,H_ACTIVE), then front porch, sync, back porch. Vertical uses the same order.
- Decode per the current counters:
  - hs = hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - hb = hCnt < H_ACTIVE
  - vs and vb are decoded the same way from vCnt.
- Output stage registers, loaded on PixEn:
  - hSync←hs, vSync←vs, hBright←hb, vBright←vb
  - VidOut ← (hb&&vb) ? PixIn : 0
- nhSync/nvSync are always the inverse of hSync/vSync.
- LineStart = PixEn && hCnt==0.
- FrameStart = PixEn && hCnt==0 && vCnt==0.

## Timing
- Reset values (CLR high at an edge):
  - div=0, hCnt=vCnt=0
  - hSync=vSync=0, nhSync=nvSync=1
  - hBright=vBright=0, VidOut=0
  - PixEn=1 if CLK_DIV=1, else 0
- CLR overrides everything, including mid-line and mid-frame; no partial state survives.
- First PixEn after release:
  - CLK_DIV-th cycle after CLR deasserts.
  - FrameStart and LineStart fire with it, with PixX=PixY=0.
- Latency:
  - Sync, bright and VidOut lag PixX/PixY by exactly one pixel period (one PixEn).
  - Upstream must present PixIn for coordinate (x,y) before the next PixEn after (x,y) is shown.
- Line period = H_TOTAL·CLK_DIV CLKs. Frame period = V_TOTAL·line period.
- Simultaneous hCnt and vCnt wrap: both counters become 0 on the same PixEn; FrameStart follows on the next PixEn.
- Between PixEn edges all outputs hold their values.

## Configuration
- `VGA_TEST_PATTERN_EN` defined:
  - PixIn is ignored.
  - An internal bar counter b (3 bits) resets to 0 on each LineStart.
  - b increments after every H_ACTIVE/8 active pixels.
  - VidOut channels are R = all-ones if b[2], G = b[1], B = b[0], each channel RGB_W/3 bits.
  - Blanking still forces VidOut to 0.
- Undefined: VidOut sources PixIn as described; no pattern logic is synthesised.

## Test plan
Bench parameters for all scenarios: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), CLK_DIV=2, RGB_W=3.
- Reset, then release CLR: all outputs hold reset values. First PixEn arrives 2 CLKs later with FrameStart=1, PixX=0, PixY=0.
- Free run for 3 lines:
  - PixEn period is 2 CLK; LineStart period is 28 CLK.
  - hSync is high for 6 CLK per line, starting one PixEn after PixX=10.
  - nhSync is always ~hSync.
- Free run for 2 frames:
  - FrameStart spacing is 224 CLK.
  - vSync is high for 56 CLK, starting one pixel after (PixX,PixY)=(0,5).
  - vBright is high for lines 0–3 only.
- Drive PixIn=3'b101 constantly: VidOut=101 exactly while hBright&&vBright, otherwise 000, with a one-PixEn lag.
- Assert CLR for 1 CLK at PixX=6, PixY=2: on the next edge counters are 0, syncs are inactive, VidOut=0. Restart matches the reset-release scenario.
- With `VGA_TEST_PATTERN_EN` defined: VidOut steps 000,001,010,…,111, one value per visible pixel, on every active line. PixIn toggling has no effect.
